// File: rtl/calc_entry_if.sv
// Command-pop, operand display and operation-request signals for calc_entry.
// The master modport is the calc_entry side; slave is the environment side.
interface calc_entry_if #(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned IC_N   = 5
);
  localparam int unsigned LW = $clog2(DIGITS + 1);
  localparam int unsigned BW = 4 * DIGITS;

  logic [IC_N-1:0] cmd;
  logic            ack;
  logic [BW-1:0]   entry_bcd;
  logic [LW-1:0]   entry_len;
  logic            entry_full;
  logic            op_valid;
  logic [2:0]      op_code;
  logic [BW-1:0]   op_operand;
  logic            op_ready;

  modport master (
    input  cmd, op_ready,
    output ack, entry_bcd, entry_len, entry_full, op_valid, op_code, op_operand
  );

  modport slave (
    output cmd, op_ready,
    input  ack, entry_bcd, entry_len, entry_full, op_valid, op_code, op_operand
  );
endinterface

// File: rtl/calc_entry.sv
// Calculator entry stage: pops keypad commands, builds a BCD operand and issues
// operator requests. Optional macro CALC_ENTRY_BACKSPACE_EN turns 'C' into backspace.
module calc_entry #(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned IC_N   = 5
) (
  input logic          clk,
  input logic          rst_n,
  calc_entry_if.master bus
);
  localparam int unsigned LW = $clog2(DIGITS + 1);
  localparam int unsigned BW = 4 * DIGITS;

  typedef enum logic [1:0] {FETCH, EXEC, ISSUE} state_e;

  state_e        state_q, state_d;
  logic [3:0]    code_q, code_d;
  logic          ack_q, ack_d;
  logic [BW-1:0] entry_bcd_q, entry_bcd_d;
  logic [LW-1:0] entry_len_q, entry_len_d;
  logic          op_valid_q, op_valid_d;
  logic [2:0]    op_code_q, op_code_d;
  logic [BW-1:0] op_operand_q, op_operand_d;
  logic          entry_full_c;

  assign entry_full_c = (entry_len_q == LW'(DIGITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      code_q       <= '0;
      ack_q        <= 1'b0;
      entry_bcd_q  <= '0;
      entry_len_q  <= '0;
      op_valid_q   <= 1'b0;
      op_code_q    <= '0;
      op_operand_q <= '0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      ack_q        <= ack_d;
      entry_bcd_q  <= entry_bcd_d;
      entry_len_q  <= entry_len_d;
      op_valid_q   <= op_valid_d;
      op_code_q    <= op_code_d;
      op_operand_q <= op_operand_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    ack_d        = 1'b0;
    entry_bcd_d  = entry_bcd_q;
    entry_len_d  = entry_len_q;
    op_valid_d   = op_valid_q;
    op_code_d    = op_code_q;
    op_operand_d = op_operand_q;

    case (state_q)
      FETCH: begin
        if (bus.cmd[IC_N-1]) begin
          code_d  = bus.cmd[3:0];
          ack_d   = 1'b1;
          state_d = EXEC;
        end
      end
      // Command input is not looked at here, so a held command pops only once.
      EXEC: begin
        state_d = FETCH;
        if (code_q <= 4'd9) begin
          if (!entry_full_c && !((entry_len_q == '0) && (code_q == 4'd0))) begin
            entry_bcd_d = {entry_bcd_q[BW-5:0], code_q};
            entry_len_d = entry_len_q + LW'(1);
          end
        end else begin
`ifdef CALC_ENTRY_BACKSPACE_EN
          if ((code_q == 4'd15) && (entry_len_q != '0)) begin
            entry_bcd_d = entry_bcd_q >> 4;
            entry_len_d = entry_len_q - LW'(1);
          end else
`endif
          begin
            op_valid_d   = 1'b1;
            op_code_d    = 3'(code_q - 4'd10);
            op_operand_d = (code_q == 4'd15) ? '0 : entry_bcd_q;
            entry_bcd_d  = '0;
            entry_len_d  = '0;
            state_d      = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (bus.op_ready) begin
          op_valid_d = 1'b0;
          state_d    = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign bus.ack        = ack_q;
  assign bus.entry_bcd  = entry_bcd_q;
  assign bus.entry_len  = entry_len_q;
  assign bus.entry_full = entry_full_c;
  assign bus.op_valid   = op_valid_q;
  assign bus.op_code    = op_code_q;
  assign bus.op_operand = op_operand_q;
endmodule

// File: tb/tb_calc_entry.sv
// Scoreboard bench for calc_entry: digit-list reference model, decoupled monitor.
module tb_calc_entry;
  localparam int unsigned DIGITS = 8;
  localparam int unsigned IC_N   = 5;

  typedef struct {
    logic [31:0] bcd;
    int          len;
  } ent_t;

  typedef struct {
    logic [2:0]  code;
    logic [31:0] operand;
    int          cycles;
  } op_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;

  int   dq[$];
  ent_t ent_q[$];
  op_t  op_q[$];

  calc_entry_if #(.DIGITS(DIGITS), .IC_N(IC_N)) bus ();

  calc_entry #(.DIGITS(DIGITS), .IC_N(IC_N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
  endtask

  // Operand value as the keypad user would read it: digits in typing order.
  function automatic logic [31:0] pack();
    logic [31:0] v;
    v = '0;
    foreach (dq[i]) v = v * 32'd16 + 32'(dq[i]);
    return v;
  endfunction

  task automatic model(input int code, output bit issue, output op_t o);
    bit bs;
    issue = 1'b0;
    bs    = 1'b0;
    o     = '{3'd0, 32'd0, 0};
    if (code <= 9) begin
      if (!(dq.size() == 0 && code == 0) && dq.size() < DIGITS) dq.push_back(code);
    end else if (code < 15) begin
      issue     = 1'b1;
      o.code    = 3'(code - 10);
      o.operand = pack();
      dq.delete();
    end else begin
`ifdef CALC_ENTRY_BACKSPACE_EN
      bs = (dq.size() > 0);
`endif
      if (bs) void'(dq.pop_back());
      else begin
        issue     = 1'b1;
        o.code    = 3'd5;
        o.operand = 32'd0;
        dq.delete();
      end
    end
    ent_q.push_back('{pack(), dq.size()});
  endtask

  // Offer one command, wait for its pop, then serve any request with k wait cycles.
  task automatic send(input int code, input int k_in, input bit hold);
    bit  got;
    bit  issue;
    op_t o;
    int  k;
    k = (k_in < 0) ? int'($urandom_range(0, 4)) : k_in;
    @(posedge clk); #1;
    bus.cmd = {1'b1, 4'(code)};
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.ack) begin
        got = 1'b1;
        break;
      end
    end
    bus.cmd = '0;
    chk("ack_timeout", 64'(got), 64'd1);
    if (!got) return;
    model(code, issue, o);
    if (!issue || hold) return;
    o.cycles = k + 1;
    op_q.push_back(o);
    got = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.op_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("op_valid_timeout", 64'(got), 64'd1);
    repeat (k) begin
      @(posedge clk); #1;
    end
    bus.op_ready = 1'b1;
    @(posedge clk); #1;
    bus.op_ready = 1'b0;
  endtask

  task automatic check_entry(input string name, input logic [31:0] bcd, input int len);
    @(posedge clk); #1;
    chk({name, "_bcd"}, 64'(bus.entry_bcd), 64'(bcd));
    chk({name, "_len"}, 64'(bus.entry_len), 64'(len));
    chk({name, "_full"}, 64'(bus.entry_full), 64'(len == DIGITS));
  endtask

  task automatic idle_gap();
    int g;
    g = int'($urandom_range(0, 3));
    repeat (g) begin
      @(posedge clk); #1;
      bus.op_ready = 1'b1 & 1'($urandom);
    end
    bus.op_ready = 1'b0;
  endtask

  // Monitor: checks the entry one cycle after each pop and each accepted request.
  bit          pend;
  bit          prev_ack;
  int          vcount;
  logic [2:0]  held_code;
  logic [31:0] held_operand;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend     = 1'b0;
      prev_ack = 1'b0;
      vcount   = 0;
    end else begin
      if (pend) begin
        pend = 1'b0;
        chk("entry_expected", 64'(ent_q.size() > 0), 64'd1);
        if (ent_q.size() > 0) begin
          ent_t e;
          e = ent_q.pop_front();
          chk("entry_bcd", 64'(bus.entry_bcd), 64'(e.bcd));
          chk("entry_len", 64'(bus.entry_len), 64'(e.len));
          chk("entry_full", 64'(bus.entry_full), 64'(e.len == DIGITS));
        end
      end
      if (bus.ack) begin
        chk("ack_single_cycle", 64'(prev_ack), 64'd0);
        pend = 1'b1;
      end
      prev_ack = bus.ack;
      if (bus.op_valid) begin
        chk("ack_during_issue", 64'(bus.ack), 64'd0);
        if (vcount == 0) begin
          held_code    = bus.op_code;
          held_operand = bus.op_operand;
        end else begin
          chk("op_code_stable", 64'(bus.op_code), 64'(held_code));
          chk("op_operand_stable", 64'(bus.op_operand), 64'(held_operand));
        end
        vcount++;
        if (bus.op_ready) begin
          chk("op_expected", 64'(op_q.size() > 0), 64'd1);
          if (op_q.size() > 0) begin
            op_t o;
            o = op_q.pop_front();
            chk("op_code", 64'(bus.op_code), 64'(o.code));
            chk("op_operand", 64'(bus.op_operand), 64'(o.operand));
            chk("op_valid_cycles", 64'(vcount), 64'(o.cycles));
          end
          vcount = 0;
        end
      end
    end
  end

  initial begin
    checks       = 0;
    passes       = 0;
    rst_n        = 1'b0;
    bus.cmd      = '0;
    bus.op_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 64'(bus.ack), 64'd0);
    chk("rst_op_valid", 64'(bus.op_valid), 64'd0);
    chk("rst_op_code", 64'(bus.op_code), 64'd0);
    chk("rst_op_operand", 64'(bus.op_operand), 64'd0);
    chk("rst_entry_bcd", 64'(bus.entry_bcd), 64'd0);
    chk("rst_entry_len", 64'(bus.entry_len), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("idle_ack", 64'(bus.ack), 64'd0);
      chk("idle_op_valid", 64'(bus.op_valid), 64'd0);
      chk("idle_entry_bcd", 64'(bus.entry_bcd), 64'd0);
    end

    send(3, -1, 1'b0); send(0, -1, 1'b0); send(7, -1, 1'b0);
    check_entry("dir_307", 32'h0000_0307, 3);
    send(14, 0, 1'b0);

    send(0, -1, 1'b0); send(0, -1, 1'b0); send(5, -1, 1'b0);
    check_entry("dir_lead0", 32'h0000_0005, 1);
    send(15, 2, 1'b0);

    for (int d = 1; d <= 9; d++) send(d, -1, 1'b0);
    check_entry("dir_full", 32'h1234_5678, 8);
    send(13, -1, 1'b0);

    send(4, -1, 1'b0); send(2, -1, 1'b0);
    send(10, 4, 1'b0);
    check_entry("dir_after_add", 32'h0, 0);

    send(4, -1, 1'b0); send(2, -1, 1'b0);
    send(15, 1, 1'b0);
    send(15, 1, 1'b0);
    send(15, 1, 1'b0);

    for (int n = 0; n < 250; n++) begin
      int code;
      code = (int'($urandom_range(0, 99)) < 65) ? int'($urandom_range(0, 9))
                                                : int'($urandom_range(10, 15));
      send(code, -1, 1'b0);
      idle_gap();
    end

    // Reset while a request is pending must drop it at once.
    send(6, -1, 1'b0);
    send(12, 0, 1'b1);
    @(posedge clk); #1;
    chk("pre_rst_op_valid", 64'(bus.op_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_op_valid", 64'(bus.op_valid), 64'd0);
    chk("mid_rst_entry_len", 64'(bus.entry_len), 64'd0);
    chk("mid_rst_ack", 64'(bus.ack), 64'd0);
    dq.delete();
    ent_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.op_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_op_valid", 64'(bus.op_valid), 64'd0);
    end
    bus.op_ready = 1'b0;
    send(9, -1, 1'b0);
    send(11, 3, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("op_queue_drained", 64'(op_q.size()), 64'd0);
    chk("entry_queue_drained", 64'(ent_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running expected=finished");
    $fatal(1);
  end
endmodule

// File: doc/calc_entry.md
Name: calc_entry

Overview:
- Sits directly downstream of the keypad input stage and consumes its buffered command stream through a cmd/ack handshake.
- Pops one command at a time.
- Digit commands accumulate a BCD operand for display.
- Operator commands hand the operand plus an opcode to the arithmetic core through a valid/ready handshake.

Parameters:
- DIGITS, 8, max BCD digits in the entry register.
- IC_N, 5, command width; cmd[4]=valid, cmd[3:0]=key code.
- LW (localparam), $clog2(DIGITS+1), width of entry_len.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- cmd  in  IC_N  command from input buffer; cmd[4]=1 means a command is present.
- ack  out  1  one-cycle pop strobe to input buffer.
- entry_bcd  out  4*DIGITS  current operand, digit 0 in [3:0] is least significant.
- entry_len  out  LW  number of significant digits entered, 0..DIGITS.
- entry_full  out  1  entry_len==DIGITS (combinational).
- op_valid  out  1  operation request to arithmetic core.
- op_code  out  3  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 EQ, 5 CLR.
- op_operand  out  4*DIGITS  operand latched with the request.
- op_ready  in  1  arithmetic core accepts the request this cycle.

Behaviour:
- Key codes:
  - 0-9 digit
  - 10 '+'
  - 11 '-'
  - 12 '*'
  - 13 '/'
  - 14 '='
  - 15 'C'
- Reset (Reset=0, async):
  - state=FETCH.
  - ack=0, op_valid=0, op_code=0.
  - op_operand=0, entry_bcd=0, entry_len=0.
- FETCH: if cmd[4]=1, register cmd[3:0], drive ack=1 next cycle, go to EXEC. Otherwise stay; ack=0.
- EXEC (ack high exactly this one cycle), then back to FETCH. The cmd input is ignored in EXEC, so a command cannot be popped twice.
  - Digit d, entry_len==0, d==0: no change (leading-zero suppression).
  - Digit d, 0<entry_len<DIGITS, or entry_len==0 with d!=0: entry_bcd <= {entry_bcd[4*DIGITS-5:0], d}; entry_len+1.
  - Digit when entry_full: ignored; entry unchanged.
  - Codes 10-14: op_operand <= entry_bcd; op_code <= code-10; op_valid <= 1; entry_bcd <= 0; entry_len <= 0. Go to ISSUE instead of FETCH.
  - Code 15: entry cleared; CLR request issued as for an operator (op_operand=0), go to ISSUE.
- ISSUE: hold op_valid, op_code and op_operand stable until a cycle with op_ready=1.
  - In that cycle the request is taken; op_valid=0 next cycle; go to FETCH.
  - No command is popped while in ISSUE.
  - op_ready high during the same cycle op_valid rises counts as acceptance.
- Throughput: cmd present at edge N gives ack high in cycle N+1 and entry updated at edge N+2. Next pop no earlier than ack in cycle N+3.
- An operand with entry_len==0 is issued as all-zero.
- Reset asserted mid-ISSUE drops op_valid immediately and discards the pending request.
- op_ready while not in ISSUE is ignored.

Optional Feature:
- Macro: CALC_ENTRY_BACKSPACE_EN.
- Defined, code 15 with entry_len>0: backspace only.
  - entry_bcd <= entry_bcd >> 4; entry_len-1.
  - No request is issued; return to FETCH.
- Defined, code 15 with entry_len==0: behaves as the undefined case (CLR request).
- Undefined: code 15 always clears the entry and issues CLR.

Test Plan:
- Reset release, cmd idle -> all outputs 0; ack never asserts.
- cmd={1,3},{1,0},{1,7}, each held until its ack -> three single-cycle acks; entry_bcd=0x00000307 (=307), entry_len=3.
- cmd {1,0},{1,0},{1,5} -> leading zeros suppressed: entry_bcd=5, entry_len=1.
- Nine digits 1..9 entered, DIGITS=8 -> entry_bcd=0x12345678, entry_full=1; ninth digit acked and dropped.
- Entry 42, then cmd {1,10} with op_ready held 0 for 4 cycles then 1 -> op_valid high 5 cycles with op_code=0, op_operand=0x42; ack idle during wait; entry cleared.
- Entry 42, cmd {1,15}:
  - Macro undefined: CLR issued with op_operand=0.
  - Macro defined: entry_bcd=4, entry_len=1, no op_valid.
  - Second {1,15}: first clears to 0 with no op_valid; third issues CLR.
